// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory pipeline stage.
package dmem_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    // Size code 3 behaves like a word access.
    function automatic logic is_misaligned(
        input logic [1:0] size,
        input logic [1:0] addr
    );
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr[0];
            default: return addr != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load lane shifter and sign/zero extender.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      addr,
    input  logic [1:0]      size,
    input  logic            uns,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = word >> {addr, 3'b000};
        case (size)
            SZ_BYTE: data = {{24{~uns & shifted[7]}}, shifted[7:0]};
            SZ_HALF: data = {{16{~uns & shifted[15]}}, shifted[15:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/dmem_stage.sv
// Data-memory stage: word-organised RAM with byte enables, a fixed
// wait-state FSM and registered, extended load responses.
module dmem_stage
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1,
    parameter int IDX_W       = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_read,
    input  logic            req_write,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    output logic            rsp_valid,
    output logic [31:0]     rsp_rdata,
    output logic [31:0]     rsp_alu_result,
    output logic            rsp_misaligned,
    output logic            busy
);

    localparam int INIT_IDX = 20 % DEPTH;
    localparam logic [3:0] CNT_INIT =
        4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    logic [XLEN-1:0] mem [DEPTH] = '{INIT_IDX: XLEN'(100), default: '0};

    state_e     state, nxt;
    logic [3:0] cnt, cnt_nxt;

    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        uns_q, rd_q, wr_q;

    logic            accept, wr_en, cur_mis;
    logic [31:0]     cur_addr;
    logic [1:0]      cur_size;
    logic            cur_uns, cur_rd, cur_wr;
    logic [IDX_W-1:0] idx;
    logic [3:0]      be;
    logic [XLEN-1:0] wlane, ld_data;

    assign req_ready = (state == IDLE) & ~reset;
    assign rsp_valid = (state == RESP) & ~reset;
    assign busy      = (state != IDLE) & ~reset;
    assign accept    = req_valid & req_ready;

    // In IDLE the live request is used so zero-wait loads can read at once.
    assign cur_addr = (state == IDLE) ? req_addr     : addr_q;
    assign cur_size = (state == IDLE) ? req_size     : size_q;
    assign cur_uns  = (state == IDLE) ? req_unsigned : uns_q;
    assign cur_rd   = (state == IDLE) ? req_read     : rd_q;
    assign cur_wr   = (state == IDLE) ? req_write    : wr_q;

    assign cur_mis = is_misaligned(cur_size, cur_addr[1:0]);
    assign idx     = cur_addr[IDX_W+1:2];
    assign wr_en   = accept & cur_wr & ~cur_mis;

    always_comb begin
        case (cur_size)
            SZ_BYTE: begin
                be    = 4'b0001 << cur_addr[1:0];
                wlane = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                be    = cur_addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{req_wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = req_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

    dmem_load_align u_align (
        .word (mem[idx]),
        .addr (cur_addr[1:0]),
        .size (cur_size),
        .uns  (cur_uns),
        .data (ld_data)
    );

    always_comb begin
        nxt     = state;
        cnt_nxt = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    nxt     = (WAIT_STATES == 0) ? RESP : WAIT;
                    cnt_nxt = CNT_INIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) nxt = RESP;
                else             cnt_nxt = cnt - 4'd1;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= req_addr;
            size_q <= req_size;
            uns_q  <= req_unsigned;
            rd_q   <= req_read;
            wr_q   <= req_write;
        end
    end

    // Response fields update only on entry to RESP and hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_rdata      <= '0;
            rsp_alu_result <= '0;
            rsp_misaligned <= 1'b0;
        end else if (nxt == RESP && state != RESP) begin
            rsp_rdata      <= (cur_rd & ~cur_wr & ~cur_mis) ? ld_data : '0;
            rsp_alu_result <= cur_addr;
            rsp_misaligned <= cur_mis;
        end
    end

endmodule

// File: tb/tb_dmem_stage.sv
// Self-checking bench for dmem_stage: directed table, corner sequences
// and randomized traffic against a byte-array reference model.
module tb_dmem_stage;

    localparam int DEPTH = 256;
    localparam int WS    = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_read = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready, rsp_valid, rsp_misaligned, busy;
    logic [31:0] rsp_rdata, rsp_alu_result;

    int checks = 0;
    int errors = 0;

    logic [7:0] mb [DEPTH*4];

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        logic        un;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp;
        logic        mis;
    } vec_t;

    vec_t tv[$];

    dmem_stage #(.DEPTH(DEPTH), .WAIT_STATES(WS)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_read       (req_read),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_alu_result (rsp_alu_result),
        .rsp_misaligned (rsp_misaligned),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd3) ? 4 : (1 << sz);
    endfunction

    // Reference: memory is a flat byte array; addresses wrap modulo its size.
    function automatic logic [31:0] model_access(
        input logic rd, input logic wr, input logic [1:0] sz,
        input logic un, input logic [31:0] a, input logic [31:0] wd,
        output logic mis);
        int n;
        int base;
        logic [31:0] v;
        n    = nbytes(sz);
        base = int'(a & 32'(DEPTH*4-1));
        v    = 32'd0;
        mis  = (a % 32'(n)) != 32'd0;
        if (mis) return 32'd0;
        if (wr) begin
            for (int k = 0; k < n; k++) mb[base+k] = wd[8*k +: 8];
            return 32'd0;
        end
        if (!rd) return 32'd0;
        for (int k = 0; k < n; k++) v = v | (32'(mb[base+k]) << (8*k));
        if (!un && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
        return v;
    endfunction

    function automatic vec_t mk(input string nm, input logic rd,
        input logic wr, input logic [1:0] sz, input logic un,
        input logic [31:0] a, input logic [31:0] wd,
        input logic [31:0] exp, input logic mis);
        vec_t v;
        v.name = nm; v.rd = rd; v.wr = wr; v.sz = sz; v.un = un;
        v.a = a; v.wd = wd; v.exp = exp; v.mis = mis;
        return v;
    endfunction

    task automatic do_req(input logic rd, input logic wr,
        input logic [1:0] sz, input logic un, input logic [31:0] a,
        input logic [31:0] wd, output logic [31:0] rdata,
        output logic [31:0] alu, output logic mis, output int lat);
        int w;
        @(negedge clk);
        req_read = rd; req_write = wr; req_size = sz;
        req_unsigned = un; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (w >= 20) chk("accept_timeout", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = rsp_rdata;
        alu   = rsp_alu_result;
        mis   = rsp_misaligned;
        @(posedge clk);
        #1;
        chk("rsp_single_cycle", 32'(rsp_valid), 32'd0);
    endtask

    task automatic run(input string nm, input logic rd, input logic wr,
        input logic [1:0] sz, input logic un, input logic [31:0] a,
        input logic [31:0] wd, input logic use_tab,
        input logic [31:0] t_exp, input logic t_mis);
        logic [31:0] e, r, alu;
        logic em, m;
        int lat;
        e = model_access(rd, wr, sz, un, a, wd, em);
        if (use_tab) begin
            e  = t_exp;
            em = t_mis;
        end
        do_req(rd, wr, sz, un, a, wd, r, alu, m, lat);
        chk({nm, "_rdata"}, r, e);
        chk({nm, "_mis"}, 32'(m), 32'(em));
        chk({nm, "_alu"}, alu, a);
        chk({nm, "_lat"}, 32'(lat), 32'(WS + 1));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic        dm;
        logic [1:0]  op, sz;
        logic        un;
        logic [31:0] a;
        int          acc [2];
        int          n;

        for (int i = 0; i < DEPTH*4; i++) mb[i] = 8'd0;
        mb[80] = 8'd100;

        tv.push_back(mk("lw50",    1, 0, 2, 0, 32'h50, 0, 32'd100, 0));
        tv.push_back(mk("sb41",    0, 1, 0, 0, 32'h41, 32'hAB, 0, 0));
        tv.push_back(mk("lb41",    1, 0, 0, 0, 32'h41, 0, 32'hFFFFFFAB, 0));
        tv.push_back(mk("lbu41",   1, 0, 0, 1, 32'h41, 0, 32'h000000AB, 0));
        tv.push_back(mk("lw40",    1, 0, 2, 0, 32'h40, 0, 32'h0000AB00, 0));
        tv.push_back(mk("sh43",    0, 1, 1, 0, 32'h43, 32'hFFFF, 0, 1));
        tv.push_back(mk("lw40b",   1, 0, 2, 0, 32'h40, 0, 32'h0000AB00, 0));
        tv.push_back(mk("sw41",    0, 1, 2, 0, 32'h41, 32'h99999999, 0, 1));
        tv.push_back(mk("lw40c",   1, 0, 2, 0, 32'h40, 0, 32'h0000AB00, 0));
        tv.push_back(mk("sw400",   0, 1, 2, 0, 32'h400, 32'hDEADBEEF, 0, 0));
        tv.push_back(mk("lw0",     1, 0, 2, 0, 32'h0, 0, 32'hDEADBEEF, 0));
        tv.push_back(mk("lh2",     1, 0, 1, 0, 32'h2, 0, 32'hFFFFDEAD, 0));
        tv.push_back(mk("lhu2",    1, 0, 1, 1, 32'h2, 0, 32'h0000DEAD, 0));
        tv.push_back(mk("lb3",     1, 0, 0, 0, 32'h3, 0, 32'hFFFFFFDE, 0));
        tv.push_back(mk("lw2",     1, 0, 2, 0, 32'h2, 0, 0, 1));
        tv.push_back(mk("pass",    0, 0, 2, 0, 32'h1234, 0, 0, 0));
        tv.push_back(mk("rdwr8",   1, 1, 2, 0, 32'h8, 32'h11223344, 0, 0));
        tv.push_back(mk("lw8",     1, 0, 2, 0, 32'h8, 0, 32'h11223344, 0));
        tv.push_back(mk("sz3",     1, 0, 3, 0, 32'h8, 0, 32'h11223344, 0));
        tv.push_back(mk("shA",     0, 1, 1, 0, 32'hA, 32'hAAAA5566, 0, 0));
        tv.push_back(mk("lw8b",    1, 0, 2, 0, 32'h8, 0, 32'h55663344, 0));
        tv.push_back(mk("sbhi",    0, 1, 0, 0, 32'hFFFFFC0B, 32'h77, 0, 0));
        tv.push_back(mk("lw8c",    1, 0, 2, 0, 32'h8, 0, 32'h77663344, 0));

        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_alu", rsp_alu_result, 32'd0);
        chk("rst_mis", 32'(rsp_misaligned), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);

        foreach (tv[i])
            run(tv[i].name, tv[i].rd, tv[i].wr, tv[i].sz, tv[i].un,
                tv[i].a, tv[i].wd, 1'b1, tv[i].exp, tv[i].mis);

        // Back-to-back requests with req_valid held high.
        @(negedge clk);
        req_read = 1; req_write = 0; req_size = 2; req_unsigned = 0;
        req_addr = 32'h50; req_valid = 1'b1;
        n = 0;
        acc[0] = 0;
        acc[1] = 0;
        for (int c = 0; c < 16; c++) begin
            if (n < 2) begin
                if (req_ready) begin
                    acc[n] = c;
                    n++;
                end
                chk("tp_ready_vs_busy", 32'(req_ready), 32'(!busy));
                @(posedge clk);
                #1;
                if (n == 2) req_valid = 1'b0;
                @(negedge clk);
            end
        end
        req_valid = 1'b0;
        chk("tp_accepts", 32'(n), 32'd2);
        chk("tp_interval", 32'(acc[1] - acc[0]), 32'(WS + 2));
        repeat (WS + 3) @(posedge clk);

        // Reset during WAIT: committed store stays, response is dropped.
        @(negedge clk);
        req_read = 0; req_write = 1; req_size = 2; req_unsigned = 0;
        req_addr = 32'h80; req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
        chk("rw_pre_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        void'(model_access(0, 1, 2'd2, 0, 32'h80, 32'hCAFEF00D, dm));
        chk("rw_busy", 32'(busy), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        req_addr = 32'h84; req_wdata = 32'h12345678; req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("rw_no_rsp", 32'(rsp_valid), 32'd0);
            chk("rw_ready_low", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        req_valid = 1'b0;
        #1;
        chk("rw_ready_after", 32'(req_ready), 32'd1);
        run("rw_lw80", 1, 0, 2, 0, 32'h80, 0, 1'b1, 32'hCAFEF00D, 1'b0);
        run("rw_lw84", 1, 0, 2, 0, 32'h84, 0, 1'b1, 32'h0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            op = 2'($urandom_range(0, 3));
            sz = 2'($urandom_range(0, 3));
            un = 1'($urandom_range(0, 1));
            a  = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 127));
            run($sformatf("rnd%0d", i), op[0], op[1], sz, un, a,
                $urandom, 1'b0, 32'd0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_stage.md
DMEM_STAGE -- requirements
Module: dmem_stage

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit words in data memory; power of two, at least 4.
REQ-002 Parameter WAIT_STATES, default 1, range 0..15: extra cycles between request acceptance and response.
REQ-003 Parameter IDX_W, derived as log2(DEPTH): word-index width.
REQ-004 clk  in  1  clock; all state updates on its rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  request can be accepted this cycle.
REQ-008 req_read  in  1  load request.
REQ-009 req_write  in  1  store request.
REQ-010 req_size  in  2  access size: byte, half or word, as encoded in the shared package.
REQ-011 req_unsigned  in  1  zero-extend loads when 1; sign-extend when 0.
REQ-012 req_addr  in  32  byte address (ALU result).
REQ-013 req_wdata  in  32  store data (reg2 data); stored bytes are taken from the low lanes.
REQ-014 rsp_valid  out  1  single-cycle response strobe.
REQ-015 rsp_rdata  out  32  extended load data.
REQ-016 rsp_alu_result  out  32  req_addr captured at acceptance, returned unchanged.
REQ-017 rsp_misaligned  out  1  the request violated alignment and was suppressed.
REQ-018 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-019 The FSM SHALL have three states: IDLE, WAIT, RESP. req_ready SHALL be high only in IDLE.
REQ-020 A request SHALL be accepted on any edge where req_valid and req_ready are both high. On acceptance the block SHALL capture address, size, unsigned flag and operation type.
REQ-021 On acceptance, the FSM SHALL move to WAIT and load its counter with WAIT_STATES-1 when WAIT_STATES>0. When WAIT_STATES=0 it SHALL go directly to RESP.
REQ-022 In WAIT, the counter SHALL decrement each cycle. At count 0 the FSM SHALL move to RESP.
REQ-023 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE.
REQ-024 Response latency SHALL be WAIT_STATES+1 cycles after acceptance. Throughput SHALL be one request per WAIT_STATES+2 cycles.
REQ-025 Word index SHALL be req_addr[IDX_W+1:2]. Upper address bits SHALL be ignored, so addresses wrap modulo DEPTH words.
REQ-026 A store SHALL commit on the acceptance edge:
- byte: byte enable selected by addr[1:0]
- half: upper or lower half selected by addr[1]
- word: all four lanes
REQ-027 Alignment violations are: half with addr[0]=1; word with addr[1:0]!=0. A violating request SHALL set rsp_misaligned=1, perform no write, and return rsp_rdata=0.
REQ-028 Load data SHALL be read from the array in the last cycle before RESP and registered into rsp_rdata. It SHALL be lane-shifted by addr[1:0] and extended to 32 bits per req_unsigned.
REQ-029 A request with neither read nor write SHALL be a pass-through: same latency, rsp_rdata=0, rsp_alu_result valid.
REQ-030 A request with both read and write SHALL be treated as a store only; rsp_rdata=0.
REQ-031 rsp_rdata, rsp_misaligned and rsp_alu_result SHALL hold their values until the next response, and are meaningful only while rsp_valid=1.
REQ-032 At time zero, memory word 20 SHALL be initialised to 100 and all other words to 0.

Reset
REQ-033 While reset=1, the block SHALL drive: state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_alu_result 0, rsp_misaligned 0, busy 0, req_ready 0. After reset deasserts, req_ready SHALL be 1.
REQ-034 Reset during WAIT or RESP SHALL abort the response. A store already committed SHALL remain, and memory contents SHALL never be cleared by reset.
REQ-035 No request SHALL be accepted on an edge where reset=1.

Structure
REQ-036 Package dmem_pkg SHALL hold:
- size_e: SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2; value 3 is treated as word
- state_e: IDLE, WAIT, RESP
- the data-width constant 32
REQ-037 Sub-module dmem_load_align SHALL be combinational. Inputs: word, addr[1:0], size, unsigned. Output: extended data.
REQ-038 The memory array, FSM and byte-enable logic SHALL reside in dmem_stage.

Verification
REQ-039 Reset, then lw 0x50 with WAIT_STATES=1 -> rsp_valid exactly 2 cycles after acceptance, rsp_rdata=100, rsp_alu_result=0x50.
REQ-040 sb 0xAB to 0x41, then three loads:
- lb 0x41 -> 0xFFFFFFAB
- lbu 0x41 -> 0x000000AB
- lw 0x40 -> 0x0000AB00
REQ-041 sh to 0x43 -> rsp_misaligned=1, rsp_rdata=0; a following lw 0x40 returns the same value it returned before the sh.
REQ-042 req_valid held high for two requests -> req_ready low during WAIT and RESP; second request accepted exactly WAIT_STATES+2 cycles after the first.
REQ-043 Reset asserted in WAIT -> no rsp_valid pulse for that request; req_ready=1 on the first cycle after reset deasserts.
REQ-044 DEPTH=256: sw 0xDEADBEEF to 0x400, then lw 0x0 -> 0xDEADBEEF (wrap-around).
